inst_mem_loader: RTL and testbench

//  Instruction-memory responder for the pipeline fetch port, with a byte-serial program loader.
//  - Serves the fetch reads with a registered 1-cycle latency.
//  - Accepts a program as a valid/ready byte stream. Bytes are packed little-endian into
//    32-bit words and written from word 0 upward.
//  - Holds ld_busy high while loading, so the core stalls fetch and ignores rdata.

---
 rtl/inst_mem_loader.sv | 186 ++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// ============================================================================
// Module      : inst_mem_loader
// Description : Instruction memory for the fetch port. Reads have a
//               registered 1-cycle latency. A byte-serial valid/ready
//               loader packs bytes little-endian into 32-bit words and
//               writes them from word 0 upward.
//               Optional macro INST_MEM_PARITY_EN adds one even-parity bit
//               per word and drives o_parity_err on reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata,
    output logic              o_rvalid,
    input  logic              i_ld_start,
    input  logic [ADDR_W:0]   i_ld_words,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_byte,
    output logic              o_ld_ready,
    output logic              o_ld_busy,
    output logic              o_ld_done,
    output logic              o_parity_err
);

    localparam int              c_DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_N   = c_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ONE_N     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W-1:0] r_wptr;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic [31:0]       r_mem [c_DEPTH];
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              w_accept;
    logic              w_ld_ready;
    logic              w_ld_busy;
    logic              w_ld_done;
    logic [ADDR_W:0]   w_n_clamped;

    // Requests longer than the array are clamped so wptr never wraps.
    assign w_n_clamped = (i_ld_words > c_DEPTH_N) ? c_DEPTH_N : i_ld_words;
    assign w_accept    = i_ld_valid & w_ld_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_ld_ready   = 1'b0;
        w_ld_busy    = 1'b1;
        w_ld_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ld_busy = 1'b0;
                if (i_ld_start) begin
                    w_state_next = (w_n_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld_ready = 1'b1;
                if (i_ld_valid && (r_byte_cnt == 2'd3)) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_next = ((r_word_cnt + c_ONE_N) == r_n) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                w_ld_done    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Loader datapath: length latch, byte packing, write pointer and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n        <= '0;
            r_word_cnt <= '0;
            r_wptr     <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_ld_start) begin
                r_n        <= w_n_clamped;
                r_word_cnt <= '0;
                r_wptr     <= '0;
                r_byte_cnt <= 2'd0;
            end else if ((r_state == S_LOAD) && w_accept) begin
                r_word[{r_byte_cnt, 3'b000} +: 8] <= i_ld_byte;
                r_byte_cnt                        <= r_byte_cnt + 2'd1;
            end else if (r_state == S_COMMIT) begin
                r_wptr     <= r_wptr + c_ONE_PTR;
                r_word_cnt <= r_word_cnt + c_ONE_N;
            end
        end
    end

    // Word write on COMMIT; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (r_state == S_COMMIT) begin
            r_mem[r_wptr] <= r_word;
        end
    end

    // Fetch read port: NOP while loading, hold rdata when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= NOP_INST;
            r_rvalid <= 1'b0;
        end else if (w_ld_busy) begin
            r_rdata  <= NOP_INST;
            r_rvalid <= 1'b0;
        end else if (i_re) begin
            r_rdata  <= r_mem[i_raddr];
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic r_par [c_DEPTH];
    logic r_parity_err;

    // Even-parity bit stored alongside each committed word.
    always_ff @(posedge clk) begin
        if (r_state == S_COMMIT) begin
            r_par[r_wptr] <= ^r_word;
        end
    end

    // Parity check updated together with rvalid on each accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (!w_ld_busy && i_re) begin
            r_parity_err <= r_par[i_raddr] ^ (^r_mem[i_raddr]);
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_rdata    = r_rdata;
    assign o_rvalid   = r_rvalid;
    assign o_ld_ready = w_ld_ready;
    assign o_ld_busy  = w_ld_busy;
    assign o_ld_done  = w_ld_done;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Directed bench for inst_mem_loader: loads, fetch vectors
//               from a table, backpressure, reset mid-load, zero-length and
//               clamped-length loads.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_mem_loader;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_re;
    logic [ADDR_W-1:0] i_raddr;
    logic [31:0]       o_rdata;
    logic              o_rvalid;
    logic              i_ld_start;
    logic [ADDR_W:0]   i_ld_words;
    logic              i_ld_valid;
    logic [7:0]        i_ld_byte;
    logic              o_ld_ready;
    logic              o_ld_busy;
    logic              o_ld_done;
    logic              o_parity_err;

    inst_mem_loader #(.ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_re         (i_re),
        .i_raddr      (i_raddr),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .i_ld_start   (i_ld_start),
        .i_ld_words   (i_ld_words),
        .i_ld_valid   (i_ld_valid),
        .i_ld_byte    (i_ld_byte),
        .o_ld_ready   (o_ld_ready),
        .o_ld_busy    (o_ld_busy),
        .o_ld_done    (o_ld_done),
        .o_parity_err (o_parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                phase;
        logic              re;
        logic [ADDR_W-1:0] raddr;
        logic [31:0]       rdata;
        logic              rvalid;
    } fvec_t;

    fvec_t      tab[18];
    logic [7:0] byte_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         busy_cyc, done_cnt, taken, blocked_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply the fetch vectors of one phase; each is checked one edge later.
    task automatic run_fetch(input int phase);
        for (int i = 0; i < 18; i++) begin
            if (tab[i].phase == phase) begin
                i_re    = tab[i].re;
                i_raddr = tab[i].raddr;
                @(negedge clk);
                check($sformatf("p%0d_v%0d_rdata", phase, i), o_rdata, tab[i].rdata);
                check($sformatf("p%0d_v%0d_rvalid", phase, i), o_rvalid, tab[i].rvalid);
                check($sformatf("p%0d_v%0d_perr", phase, i), o_parity_err, 1'b0);
            end
        end
        i_re = 1'b0;
    endtask

    // Stream byte_q into the loader while fetching word 0 every cycle.
    task automatic run_load(input logic [ADDR_W:0] nw, input int rst_after,
                            input int gap_mod, input bit poke_start, input int max_cyc);
        int idx;
        bit prev_busy;
        bit finished;
        busy_cyc = 0; done_cnt = 0; blocked_bad = 0;
        idx = 0; prev_busy = 1'b0; finished = 1'b0;
        i_re       = 1'b1;
        i_raddr    = '0;
        i_ld_words = nw;
        i_ld_start = 1'b1;
        @(negedge clk);
        i_ld_start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (o_ld_busy) busy_cyc++;
            if (o_ld_done) done_cnt++;
            if (prev_busy && ((o_rdata !== NOP) || (o_rvalid !== 1'b0))) blocked_bad++;
            if (!o_ld_busy) begin
                finished = 1'b1;
                break;
            end
            prev_busy = 1'b1;
            if ((rst_after >= 0) && (idx == rst_after)) begin
                i_ld_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                check("rst_async_rdata", o_rdata, NOP);
                check("rst_async_rvalid", o_rvalid, 1'b0);
                check("rst_async_ready", o_ld_ready, 1'b0);
                check("rst_async_busy", o_ld_busy, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                finished = 1'b1;
                break;
            end
            i_ld_start = poke_start && (c == 2);
            i_ld_words = (poke_start && (c == 2)) ? '0 : nw;
            i_ld_valid = (idx < byte_q.size()) && !((gap_mod > 0) && ((c % gap_mod) == gap_mod - 1));
            i_ld_byte  = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
            if (i_ld_valid && o_ld_ready) idx++;
            @(negedge clk);
        end
        i_ld_valid = 1'b0;
        i_ld_start = 1'b0;
        i_re       = 1'b0;
        taken      = idx;
        check("load_terminates", finished, 1'b1);
        check("fetch_blocked_during_load", blocked_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{1, 1'b1, 10'd1,    32'h00200113, 1'b1};
        tab[1]  = '{1, 1'b0, 10'd1,    32'h00200113, 1'b0};
        tab[2]  = '{1, 1'b1, 10'd0,    32'h00100093, 1'b1};
        tab[3]  = '{1, 1'b0, 10'd5,    32'h00100093, 1'b0};
        tab[4]  = '{1, 1'b1, 10'd1,    32'h00200113, 1'b1};
        tab[5]  = '{2, 1'b1, 10'd2,    32'h1C1B1A19, 1'b1};
        tab[6]  = '{2, 1'b1, 10'd0,    32'h14131211, 1'b1};
        tab[7]  = '{2, 1'b0, 10'd7,    32'h14131211, 1'b0};
        tab[8]  = '{2, 1'b1, 10'd1,    32'h18171615, 1'b1};
        tab[9]  = '{3, 1'b1, 10'd0,    32'h44332211, 1'b1};
        tab[10] = '{3, 1'b1, 10'd1,    32'h18171615, 1'b1};
        tab[11] = '{4, 1'b1, 10'd0,    32'h04030201, 1'b1};
        tab[12] = '{4, 1'b1, 10'd1,    32'h18171615, 1'b1};
        tab[13] = '{4, 1'b1, 10'd2,    32'h1C1B1A19, 1'b1};
        tab[14] = '{5, 1'b1, 10'd0,    32'hA5000000, 1'b1};
        tab[15] = '{5, 1'b1, 10'd1023, 32'hA50003FF, 1'b1};
        tab[16] = '{5, 1'b1, 10'd512,  32'hA5000200, 1'b1};
        tab[17] = '{5, 1'b0, 10'd3,    32'hA5000200, 1'b0};

        rst = 1'b1; i_re = 1'b0; i_raddr = '0; i_ld_start = 1'b0;
        i_ld_words = '0; i_ld_valid = 1'b0; i_ld_byte = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rdata", o_rdata, NOP);
        check("reset_rvalid", o_rvalid, 1'b0);
        check("reset_ready", o_ld_ready, 1'b0);
        check("reset_busy", o_ld_busy, 1'b0);
        check("reset_done", o_ld_done, 1'b0);
        check("reset_perr", o_parity_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word back-to-back load: 4+1+4+1+1 busy cycles.
        byte_q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        run_load(11'd2, -1, 0, 1'b0, 50);
        check("load2_busy_cycles", busy_cyc, 11);
        check("load2_done_pulses", done_cnt, 1);
        check("load2_bytes_taken", taken, 8);
        run_fetch(1);

        // Gapped stream, valid held across COMMIT, ld_start poked mid-load.
        byte_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
                   8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C};
        run_load(11'd3, -1, 3, 1'b1, 100);
        check("bp_done_pulses", done_cnt, 1);
        check("bp_bytes_taken", taken, 12);
        run_fetch(2);

        // Reset after two bytes of word 1: word 0 stays, word 1 untouched.
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(11'd2, 6, 0, 1'b0, 50);
        check("rst_bytes_taken", taken, 6);
        run_fetch(3);

        // Reload one word, then a zero-length load that must not write.
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
        run_load(11'd1, -1, 0, 1'b0, 50);
        check("reload1_busy_cycles", busy_cyc, 6);
        check("reload1_bytes_taken", taken, 4);
        run_load(11'd0, -1, 0, 1'b0, 20);
        check("zero_busy_cycles", busy_cyc, 1);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_bytes_taken", taken, 0);
        run_fetch(4);

`ifdef INST_MEM_PARITY_EN
        dut.r_par[1] = ~dut.r_par[1];
        i_re = 1'b1; i_raddr = 10'd1;
        @(negedge clk);
        check("parity_flip_err", o_parity_err, 1'b1);
        i_raddr = 10'd0;
        @(negedge clk);
        check("parity_clear_err", o_parity_err, 1'b0);
        i_re = 1'b0;
`else
        i_re = 1'b1; i_raddr = 10'd1;
        @(negedge clk);
        check("parity_tied_low", o_parity_err, 1'b0);
        i_re = 1'b0;
`endif

        // Oversized request is clamped to DEPTH words.
        byte_q.delete();
        for (int w = 0; w < DEPTH; w++) begin
            byte_q.push_back(8'(w));
            byte_q.push_back(8'(w >> 8));
            byte_q.push_back(8'h00);
            byte_q.push_back(8'hA5);
        end
        run_load(11'd2047, -1, 0, 1'b0, 6000);
        check("clamp_busy_cycles", busy_cyc, DEPTH * 5 + 1);
        check("clamp_done_pulses", done_cnt, 1);
        check("clamp_bytes_taken", taken, DEPTH * 4);
        run_fetch(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
